wishbone_arbitrator: RTL and testbench

Shares the single Wishbone manager port of the decoder among `NUM_MANAGERS` bus managers (management core, LA-driven manager, debug manager) using round-robin arbitration. Sits between the managers and `wishbone_decoder` in the interconnect. Holds each grant for a whole `cyc` cycle. Aborts transactions that are never acknowledged with a one-cycle error pulse.

---
 rtl/wishbone_arbitrator.sv | 156 +++++++++++++++
 tb/tb_wishbone_arbitrator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbitrator.sv
// Round-robin arbiter that shares the decoder's single Wishbone manager port among
// NUM_MANAGERS requesters, holding each grant for a whole cyc and aborting stalled strobes.
module wishbone_arbitrator #(
    parameter int NUM_MANAGERS   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_MANAGERS-1:0]       wbs_cyc_i_mgr,
    input  logic [NUM_MANAGERS-1:0]       wbs_stb_i_mgr,
    input  logic [NUM_MANAGERS-1:0]       wbs_we_i_mgr,
    input  logic [NUM_MANAGERS-1:0][31:0] wbs_adr_i_mgr,
    input  logic [NUM_MANAGERS-1:0][31:0] wbs_dat_i_mgr,
    input  logic [NUM_MANAGERS-1:0][3:0]  wbs_sel_i_mgr,
    output logic [NUM_MANAGERS-1:0]       wbs_ack_o_mgr,
    output logic [NUM_MANAGERS-1:0]       wbs_err_o_mgr,
    output logic [NUM_MANAGERS-1:0][31:0] wbs_dat_o_mgr,
    output logic                          wbs_cyc_o_m,
    output logic                          wbs_stb_o_m,
    output logic                          wbs_we_o_m,
    output logic [31:0]                   wbs_adr_o_m,
    output logic [31:0]                   wbs_dat_o_m,
    output logic [3:0]                    wbs_sel_o_m,
    input  logic                          wbs_ack_i_m,
    input  logic [31:0]                   wbs_dat_i_m,
    output logic [NUM_MANAGERS-1:0]       grant_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(NUM_MANAGERS);
    localparam logic [CW-1:0] TERM_COUNT = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_INIT  = IW'(NUM_MANAGERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                  state_r;
    logic [IW-1:0]           owner_r;
    logic [IW-1:0]           last_r;
    logic [NUM_MANAGERS-1:0] grant_r;
    logic [NUM_MANAGERS-1:0] err_r;
    logic [CW-1:0]           count_r;
    logic [NUM_MANAGERS-1:0] req_s;
    logic [IW-1:0]           pick_s;

    // First requester found scanning upward from last+1 with wrap-around.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_MANAGERS-1:0] req,
                                              input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        pick = last;
        for (int k = NUM_MANAGERS; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NUM_MANAGERS);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_MANAGERS-1:0] to_onehot(input logic [IW-1:0] idx);
        logic [NUM_MANAGERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign grant_o       = grant_r;
    assign wbs_err_o_mgr = err_r;

    // Request vector and round-robin candidate for the next grant.
    always_comb begin
        req_s  = wbs_cyc_i_mgr & wbs_stb_i_mgr;
        pick_s = rr_pick(req_s, last_r);
    end

    // Route the owner's bus to the decoder and the decoder's response back to the owner only.
    always_comb begin
        wbs_cyc_o_m   = 1'b0;
        wbs_stb_o_m   = 1'b0;
        wbs_we_o_m    = 1'b0;
        wbs_adr_o_m   = 32'h0000_0000;
        wbs_dat_o_m   = 32'h0000_0000;
        wbs_sel_o_m   = 4'h0;
        wbs_ack_o_mgr = '0;
        wbs_dat_o_mgr = '0;
        if (state_r == GRANT) begin
            wbs_cyc_o_m            = wbs_cyc_i_mgr[owner_r];
            wbs_stb_o_m            = wbs_stb_i_mgr[owner_r];
            wbs_we_o_m             = wbs_we_i_mgr[owner_r];
            wbs_adr_o_m            = wbs_adr_i_mgr[owner_r];
            wbs_dat_o_m            = wbs_dat_i_mgr[owner_r];
            wbs_sel_o_m            = wbs_sel_i_mgr[owner_r];
            wbs_ack_o_mgr[owner_r] = wbs_ack_i_m;
            wbs_dat_o_mgr[owner_r] = wbs_dat_i_m;
        end else begin
            wbs_cyc_o_m = 1'b0;
        end
    end

    // Arbitration FSM: grant, hold until cyc drops, abort on a strobe left un-acked too long.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            owner_r <= LAST_INIT;
            last_r  <= LAST_INIT;
            grant_r <= '0;
            err_r   <= '0;
            count_r <= '0;
        end else begin
            err_r <= '0;
            case (state_r)
                IDLE: begin
                    count_r <= '0;
                    if (|req_s) begin
                        owner_r <= pick_s;
                        last_r  <= pick_s;
                        grant_r <= to_onehot(pick_s);
                        state_r <= GRANT;
                    end
                end
                GRANT: begin
                    if (!wbs_cyc_i_mgr[owner_r]) begin
                        grant_r <= '0;
                        count_r <= '0;
                        state_r <= IDLE;
                    end else if (!wbs_stb_i_mgr[owner_r] || wbs_ack_i_m) begin
                        // An ack on the terminal count still wins over the abort.
                        count_r <= '0;
                    end else if (count_r == TERM_COUNT) begin
                        err_r   <= to_onehot(owner_r);
                        count_r <= '0;
                        state_r <= ABORT;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                ABORT: begin
                    count_r <= '0;
                    if (!wbs_cyc_i_mgr[owner_r]) begin
                        grant_r <= '0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    grant_r <= '0;
                    count_r <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_arbitrator.sv
// Self-checking bench for wishbone_arbitrator: vector table, hand-written corner
// sequences and randomized traffic, all compared against a cycle-level reference model.
module tb_wishbone_arbitrator;
    localparam int N = 3;
    localparam int T = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [N-1:0]      cyc, stb, we;
    logic [N-1:0][31:0] adr, wdat;
    logic [N-1:0][3:0] sel;
    logic              dec_ack;
    logic [31:0]       dec_dat;
    logic [N-1:0]      ack_o, err_o, grant;
    logic [N-1:0][31:0] rdat;
    logic              m_cyc, m_stb, m_we;
    logic [31:0]       m_adr, m_dat;
    logic [3:0]        m_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 = bus free), abort flag, run length of stalled strobes.
    int         m_owner;
    int         m_last;
    int         m_stall;
    bit         m_abort;
    logic [N-1:0] m_err;

    typedef struct {
        logic [N-1:0] cyc;
        logic [N-1:0] stb;
        logic         ack;
        logic [N-1:0] e_grant;
        logic         e_cyc;
        logic [N-1:0] e_ack;
        logic [N-1:0] e_err;
    } vec_t;
    vec_t tbl[$];

    wishbone_arbitrator #(.NUM_MANAGERS(N), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .nRST(nRST),
        .wbs_cyc_i_mgr(cyc), .wbs_stb_i_mgr(stb), .wbs_we_i_mgr(we),
        .wbs_adr_i_mgr(adr), .wbs_dat_i_mgr(wdat), .wbs_sel_i_mgr(sel),
        .wbs_ack_o_mgr(ack_o), .wbs_err_o_mgr(err_o), .wbs_dat_o_mgr(rdat),
        .wbs_cyc_o_m(m_cyc), .wbs_stb_o_m(m_stb), .wbs_we_o_m(m_we),
        .wbs_adr_o_m(m_adr), .wbs_dat_o_m(m_dat), .wbs_sel_o_m(m_sel),
        .wbs_ack_i_m(dec_ack), .wbs_dat_i_m(dec_dat),
        .grant_o(grant)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_stall = 0;
        m_abort = 1'b0;
        m_err   = '0;
    endtask

    task automatic model_step();
        logic [1:0] o;
        logic [1:0] i;
        if (!nRST) begin
            model_reset();
            return;
        end
        m_err = '0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                i = 2'((m_last + k) % N);
                if (m_owner < 0 && cyc[i] && stb[i]) begin
                    m_owner = int'(i);
                    m_last  = int'(i);
                end
            end
            m_stall = 0;
        end else begin
            o = 2'(m_owner);
            if (!cyc[o]) begin
                m_owner = -1;
                m_abort = 1'b0;
                m_stall = 0;
            end else if (!m_abort) begin
                if (stb[o] && !dec_ack) begin
                    m_stall++;
                    // The (T+1)-th consecutive un-acked strobe cycle triggers the abort.
                    if (m_stall > T) begin
                        m_abort = 1'b1;
                        m_err   = 3'b001 << o;
                        m_stall = 0;
                    end
                end else begin
                    m_stall = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0]       e_grant, e_ack;
        logic [N-1:0][31:0] e_dato;
        logic [2:0]         e_ctl;
        logic [31:0]        e_adr, e_dat;
        logic [3:0]         e_sel;
        logic [1:0]         o;
        e_grant = '0; e_ack = '0; e_dato = '0; e_ctl = 3'b000;
        e_adr = 32'h0; e_dat = 32'h0; e_sel = 4'h0;
        if (m_owner >= 0) begin
            o = 2'(m_owner);
            e_grant = 3'b001 << o;
            if (!m_abort) begin
                e_ctl     = {cyc[o], stb[o], we[o]};
                e_adr     = adr[o];
                e_dat     = wdat[o];
                e_sel     = sel[o];
                e_ack[o]  = dec_ack;
                e_dato[o] = dec_dat;
            end
        end
        check("mdl_grant", 128'(grant), 128'(e_grant));
        check("mdl_err",   128'(err_o), 128'(m_err));
        check("mdl_ack",   128'(ack_o), 128'(e_ack));
        check("mdl_rdat",  128'(rdat),  128'(e_dato));
        check("mdl_ctl",   128'({m_cyc, m_stb, m_we}), 128'(e_ctl));
        check("mdl_adr",   128'(m_adr), 128'(e_adr));
        check("mdl_wdat",  128'(m_dat), 128'(e_dat));
        check("mdl_sel",   128'(m_sel), 128'(e_sel));
    endtask

    task automatic sample();
        @(negedge CLK);
        check_model();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic add(input logic [N-1:0] c, input logic [N-1:0] s, input logic a,
                       input logic [N-1:0] g, input logic co, input logic [N-1:0] ao,
                       input logic [N-1:0] eo);
        vec_t v;
        v.cyc = c; v.stb = s; v.ack = a; v.e_grant = g; v.e_cyc = co; v.e_ack = ao; v.e_err = eo;
        tbl.push_back(v);
    endtask

    initial begin
        nRST = 1'b0;
        cyc = '0; stb = '0; we = '0; dec_ack = 1'b0; dec_dat = 32'h1234_5678;
        for (int i = 0; i < N; i++) begin
            adr[i]  = 32'h3000_0000 + 32'(4 * i);
            wdat[i] = 32'h5500_0000 + 32'(i);
            sel[i]  = 4'(i + 3);
        end
        wdat[1] = 32'hDEAD_BEEF;
        sel[1]  = 4'hF;
        model_reset();

        for (int k = 0; k < 2; k++) begin
            sample();
            advance();
        end
        nRST = 1'b1;

        // cyc, stb, ack, grant, cyc_o_m, ack_o, err_o
        add(3'b010, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        add(3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000);
        add(3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        add(3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        add(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 3'b100, 3'b000);
        add(3'b011, 3'b011, 1'b0, 3'b100, 1'b0, 3'b000, 3'b000);
        add(3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        add(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 3'b000);
        add(3'b110, 3'b110, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000);
        add(3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        add(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 3'b010, 3'b000);
        add(3'b101, 3'b101, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        // Timeout: five stalled cycles, then the error pulse while the decoder acks too late.
        add(3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 5; k++) add(3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000);
        add(3'b001, 3'b001, 1'b1, 3'b001, 1'b0, 3'b000, 3'b001);
        add(3'b001, 3'b001, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        // Ack exactly at the terminal count.
        add(3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++) add(3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000);
        add(3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);

        we = 3'b010;
        foreach (tbl[r]) begin
            cyc = tbl[r].cyc; stb = tbl[r].stb; dec_ack = tbl[r].ack;
            sample();
            check($sformatf("tbl%0d_grant", r), 128'(grant), 128'(tbl[r].e_grant));
            check($sformatf("tbl%0d_cyc", r),   128'(m_cyc), 128'(tbl[r].e_cyc));
            check($sformatf("tbl%0d_ack", r),   128'(ack_o), 128'(tbl[r].e_ack));
            check($sformatf("tbl%0d_err", r),   128'(err_o), 128'(tbl[r].e_err));
            advance();
        end

        // Grant hold: manager 2 reads three times while manager 0 keeps requesting.
        we = 3'b000; dec_ack = 1'b0;
        cyc = 3'b100; stb = 3'b100;
        sample();
        advance();
        cyc = 3'b101; stb = 3'b101;
        for (int r = 0; r < 3; r++) begin
            dec_ack = 1'b1;
            dec_dat = 32'hA000_0000 + 32'(r);
            sample();
            check("hold_grant", 128'(grant), 128'(3'b100));
            check("hold_rdat2", 128'(rdat[2]), 128'(32'hA000_0000 + 32'(r)));
            check("hold_rdat0", 128'(rdat[0]), 128'(32'h0));
            advance();
            dec_ack = 1'b0;
            sample();
            advance();
        end
        cyc = 3'b001; stb = 3'b001;
        sample();
        check("hold_last", 128'(grant), 128'(3'b100));
        advance();
        sample();
        check("hold_idle", 128'(grant), 128'(3'b000));
        advance();
        sample();
        check("hold_switch", 128'(grant), 128'(3'b001));
        advance();
        cyc = 3'b000; stb = 3'b000;
        for (int k = 0; k < 2; k++) begin
            sample();
            advance();
        end

        // Asynchronous reset in the middle of a granted, acked transfer.
        cyc = 3'b010; stb = 3'b010; we = 3'b010;
        sample();
        advance();
        dec_ack = 1'b1;
        sample();
        check("rst_pre_ack", 128'(ack_o), 128'(3'b010));
        #2 nRST = 1'b0;
        #1;
        check("rst_grant", 128'(grant), 128'(3'b000));
        check("rst_ack",   128'(ack_o), 128'(3'b000));
        check("rst_err",   128'(err_o), 128'(3'b000));
        check("rst_rdat",  128'(rdat),  128'(0));
        check("rst_bus",   128'({m_cyc, m_stb, m_we, m_adr, m_dat, m_sel}), 128'(0));
        model_reset();
        cyc = 3'b111; stb = 3'b111; dec_ack = 1'b0;
        advance();
        nRST = 1'b1;
        sample();
        advance();
        sample();
        check("rst_first_owner", 128'(grant), 128'(3'b001));
        advance();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) cyc[i] = ~cyc[i];
                stb[i]  = ($urandom_range(0, 3) != 0);
                we[i]   = 1'($urandom_range(0, 1));
                adr[i]  = $urandom;
                wdat[i] = $urandom;
                sel[i]  = 4'($urandom_range(0, 15));
            end
            dec_ack = ((c % 64) < 40) ? ($urandom_range(0, 3) == 0) : 1'b0;
            dec_dat = $urandom;
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
